// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - layer bias-count table and FSM state type for bias_fifo_reader
package bias_pkg;

   localparam int NUM_LAYERS = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int unsigned layer_count(input logic [2:0] layer);
      case (layer)
         3'd0:    return 8;
         3'd1:    return 16;
         3'd2:    return 32;
         3'd3:    return 49;
         3'd4:    return 10;
         default: return 0;
      endcase
   endfunction

   function automatic logic layer_valid(input logic [2:0] layer);
      return (layer < 3'(NUM_LAYERS));
   endfunction

endpackage

// File: rtl/bias_fifo_reader_if.sv
// rtl/bias_fifo_reader_if.sv - FIFO read port and bias output stream of bias_fifo_reader
interface bias_fifo_reader_if #(
   parameter int MEM_SIZE = 40
);
   logic [MEM_SIZE-1:0] fifo_rd;
   logic                fifo_empty;
   logic                fifo_rden;
   logic [MEM_SIZE-1:0] bias_data;
   logic                bias_valid;
   logic                bias_ready;
   logic                bias_last;

   modport master (
      input  fifo_rd, fifo_empty, bias_ready,
      output fifo_rden, bias_data, bias_valid, bias_last
   );

   modport slave (
      output fifo_rd, fifo_empty, bias_ready,
      input  fifo_rden, bias_data, bias_valid, bias_last
   );
endinterface

// File: rtl/bias_skid_buf.sv
// rtl/bias_skid_buf.sv - 2-entry fall-through buffer holding bias words and their last flag
module bias_skid_buf #(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_wr,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   input  logic         i_ready,
   output logic [1:0]   o_count
);
   logic [W:0] r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_pop;
   logic [W:0] w_head;

   // An arriving word is presented in the same cycle when the buffer is empty.
   assign o_valid = (r_count != 2'd0) | i_wr;
   assign w_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : {i_last, i_data};
   assign o_data  = o_valid ? w_head[W-1:0] : '0;
   assign o_last  = o_valid & w_head[W];
   assign w_pop   = o_valid & i_ready;
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (i_wr) begin
         r_mem[r_wr_ptr] <= {i_last, i_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_wr} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/bias_fifo_reader.sv
// rtl/bias_fifo_reader.sv - reads one layer's biases from a FIFO and streams them to the core
// Optional sticky err output for rejected starts: BIAS_FIFO_READER_ERR_EN
module bias_fifo_reader
   import bias_pkg::*;
#(
   parameter int MEM_SIZE  = 40,
   parameter int MEM_DEPTH = 49
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] layer_signal,
   input  logic       start,
   output logic       busy,
   output logic       done,
`ifdef BIAS_FIFO_READER_ERR_EN
   output logic       err,
`endif
   bias_fifo_reader_if.master bus
);
   localparam int CW = $clog2(MEM_DEPTH + 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_issued;
   logic          r_inflight;
   logic          r_inflight_last;
   logic          w_start_ok;
   logic          w_rden;
   logic          w_pop;
   logic          w_valid;
   logic          w_last;
   logic [1:0]    w_occ;
   logic [2:0]    w_occ_after;

   assign w_start_ok = start & (r_state == IDLE) & layer_valid(layer_signal);

   bias_skid_buf #(.W(MEM_SIZE)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (r_inflight),
      .i_data  (bus.fifo_rd),
      .i_last  (r_inflight_last),
      .o_valid (w_valid),
      .o_data  (bus.bias_data),
      .o_last  (w_last),
      .i_ready (bus.bias_ready),
      .o_count (w_occ)
   );

   assign bus.bias_valid = w_valid;
   assign bus.bias_last  = w_last;
   assign bus.fifo_rden  = w_rden;
   assign w_pop          = w_valid & bus.bias_ready;

   // Occupancy the buffer will have next cycle; a new read may issue only if a slot remains then.
   assign w_occ_after = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_next = FETCH;
         FETCH:   if (w_rden && (r_issued == r_count - 1'b1)) w_next = DRAIN;
         DRAIN:   if (w_pop && w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_rden = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         FETCH: begin
            busy   = 1'b1;
            w_rden = !bus.fifo_empty && (r_issued < r_count) && (w_occ_after < 3'd2);
         end
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count         <= '0;
         r_issued        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_count  <= CW'(layer_count(layer_signal));
            r_issued <= '0;
         end
         r_inflight <= w_rden;
         if (w_rden) begin
            r_issued        <= r_issued + 1'b1;
            r_inflight_last <= (r_issued == r_count - 1'b1);
         end
      end
   end

`ifdef BIAS_FIFO_READER_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (start && ((r_state != IDLE) || !layer_valid(layer_signal))) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_bias_fifo_reader.sv
// tb/tb_bias_fifo_reader.sv - directed self-checking bench for bias_fifo_reader
module tb_bias_fifo_reader;
   localparam int W = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] layer_signal = 3'd0;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
`ifdef BIAS_FIFO_READER_ERR_EN
   logic       err;
`endif

   bias_fifo_reader_if #(.MEM_SIZE(W)) bus ();

   bias_fifo_reader #(.MEM_SIZE(W), .MEM_DEPTH(49)) dut (
      .clk          (clk),
      .rst          (rst),
      .layer_signal (layer_signal),
      .start        (start),
      .busy         (busy),
      .done         (done),
`ifdef BIAS_FIFO_READER_ERR_EN
      .err          (err),
`endif
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // FIFO model: data valid the cycle after a pop
   logic [W-1:0] fmem [256];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   logic         fifo_clr = 1'b0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr <= wr_ptr;
      end else if (bus.fifo_rden && !bus.fifo_empty) begin
         bus.fifo_rd <= fmem[rd_ptr[7:0]];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   int           cyc = 0;
   logic [W:0]   hs_q[$];
   int           hs_cyc[$];
   int           rden_cnt = 0;
   int           rden_bad = 0;
   int           done_cnt = 0;
   int           done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.bias_valid && bus.bias_ready) begin
         hs_q.push_back({bus.bias_last, bus.bias_data});
         hs_cyc.push_back(cyc);
      end
      if (bus.fifo_rden) begin
         rden_cnt++;
         if (bus.fifo_empty) rden_bad++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_words(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         fmem[wr_ptr[7:0]] = W'(base + i);
         wr_ptr++;
      end
   endtask

   task automatic pulse_start(input logic [2:0] l, output int t0);
      @(posedge clk);
      #1;
      layer_signal = l;
      start        = 1'b1;
      t0           = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input string tag);
      int i;
      i = 0;
      while (done_cnt == d0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      #1;
      check(tag, done_cnt, d0 + 1);
   endtask

   task automatic wait_hs(input int b0, input int n, input int budget, input string tag);
      int i;
      i = 0;
      while ((hs_q.size() - b0) < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      check(tag, ((hs_q.size() - b0) >= n), 1'b1);
   endtask

   task automatic verify(input string tag, input int b0, input int n, input int base);
      check({tag, "_count"}, hs_q.size() - b0, n);
      for (int i = 0; i < n && (b0 + i) < hs_q.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), hs_q[b0 + i][W-1:0], W'(base + i));
         check($sformatf("%s_last%0d", tag, i), hs_q[b0 + i][W], (i == n - 1));
      end
   endtask

   initial begin
      int t0, b0, d0, r0;
      bus.bias_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rden", bus.fifo_rden, 1'b0);
      check("rst_valid", bus.bias_valid, 1'b0);
      check("rst_last", bus.bias_last, 1'b0);
      check("rst_data", bus.bias_data, 40'd0);
`ifdef BIAS_FIFO_READER_ERR_EN
      check("rst_err", err, 1'b0);
`endif
      rst = 1'b0;
      push_words(32'h01, 8);

      // invalid layer is ignored
      d0 = done_cnt; r0 = rden_cnt;
      pulse_start(3'd6, t0);
      repeat (5) @(posedge clk);
      #1;
      check("inv_busy", busy, 1'b0);
      check("inv_rden", rden_cnt - r0, 0);
      check("inv_done", done_cnt, d0);
`ifdef BIAS_FIFO_READER_ERR_EN
      check("inv_err", err, 1'b1);
`endif

      // layer 0, ready held high
      b0 = hs_q.size(); d0 = done_cnt; r0 = rden_cnt;
      pulse_start(3'd0, t0);
      @(negedge clk);
      check("l0_rden_c1", bus.fifo_rden, 1'b1);
      check("l0_valid_c1", bus.bias_valid, 1'b0);
      @(negedge clk);
      check("l0_valid_c2", bus.bias_valid, 1'b1);
      check("l0_data_c2", bus.bias_data, 40'h01);
      wait_done(d0, 50, "l0_done");
      verify("l0", b0, 8, 32'h01);
      check("l0_rden_cnt", rden_cnt - r0, 8);
      check("l0_done_cyc", done_cyc - t0, 10);
      if (hs_cyc.size() > 0) check("l0_done_after_last", done_cyc - hs_cyc[hs_cyc.size() - 1], 1);
      check("l0_busy_end", busy, 1'b0);

      // layer 3, ready toggling every cycle
      push_words(32'h200, 49);
      b0 = hs_q.size(); d0 = done_cnt; r0 = rden_cnt;
      pulse_start(3'd3, t0);
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
         @(posedge clk);
         #1;
         bus.bias_ready = ~bus.bias_ready;
      end
      bus.bias_ready = 1'b1;
      check("l3_done", done_cnt, d0 + 1);
      verify("l3", b0, 49, 32'h200);
      check("l3_rden_cnt", rden_cnt - r0, 49);

      // layer 1 with FIFO running dry after 5 words
      push_words(32'h300, 5);
      b0 = hs_q.size(); d0 = done_cnt;
      pulse_start(3'd1, t0);
      repeat (15) @(posedge clk);
      #1;
      check("l1_stall_count", hs_q.size() - b0, 5);
      check("l1_stall_busy", busy, 1'b1);
      check("l1_stall_rden", bus.fifo_rden, 1'b0);
      push_words(32'h305, 11);
      wait_done(d0, 100, "l1_done");
      verify("l1", b0, 16, 32'h300);

      // layer 2 with a second start while busy
      push_words(32'h400, 32);
      b0 = hs_q.size(); d0 = done_cnt;
      pulse_start(3'd2, t0);
      wait_hs(b0, 3, 50, "l2_reach3");
      #1;
      layer_signal = 3'd0;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, 200, "l2_done");
      verify("l2", b0, 32, 32'h400);
      repeat (5) @(posedge clk);
      #1;
      check("l2_no_restart_busy", busy, 1'b0);
      check("l2_no_extra_done", done_cnt, d0 + 1);
`ifdef BIAS_FIFO_READER_ERR_EN
      check("l2_err", err, 1'b1);
`endif

      // reset in the middle of layer 3
      push_words(32'h500, 49);
      b0 = hs_q.size(); d0 = done_cnt;
      pulse_start(3'd3, t0);
      wait_hs(b0, 20, 100, "abort_reach20");
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_valid", bus.bias_valid, 1'b0);
      check("abort_rden", bus.fifo_rden, 1'b0);
      check("abort_last", bus.bias_last, 1'b0);
      check("abort_data", bus.bias_data, 40'd0);
      fifo_clr = 1'b1;
      @(posedge clk);
      #1;
      fifo_clr = 1'b0;
      check("abort_done_now", done, 1'b0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, d0);
      check("abort_idle", busy, 1'b0);
`ifdef BIAS_FIFO_READER_ERR_EN
      check("abort_err_cleared", err, 1'b0);
`endif

      // normal layer 0 after the abort
      push_words(32'h600, 8);
      b0 = hs_q.size(); d0 = done_cnt; r0 = rden_cnt;
      pulse_start(3'd0, t0);
      wait_done(d0, 50, "post_done");
      verify("post", b0, 8, 32'h600);
      check("post_rden_cnt", rden_cnt - r0, 8);

      check("rden_while_empty", rden_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
